// File: rtl/alu_share_pkg.sv
// ============================================================================
// Module  : alu_share_pkg
// Brief   : Shared types and constants for the two-requester ALU arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_share_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] DZ_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_core32.sv
// ============================================================================
// Module  : alu_core32
// Brief   : Combinational 32-bit unsigned add/sub/mul/div with div-by-zero flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core32
  import alu_share_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  op_e               op,
  output logic [DATA_W-1:0] f,
  output logic              dz
);

  always_comb begin
    f  = '0;
    dz = 1'b0;
    case (op)
      OP_ADD: f = a + b + {{(DATA_W-1){1'b0}}, cin};
      OP_SUB: f = a - b;
      OP_MUL: f = a * b;
      OP_DIV: begin
        // Guarded so the divider never sees a zero divisor.
        if (b == '0) begin
          f  = DZ_RESULT;
          dz = 1'b1;
        end else begin
          f = a / b;
        end
      end
      default: f = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Round-robin share of one ALU between two valid/ready requesters,
//           registered tagged response, saturating per-requester op counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r0_cin,
  input  logic [1:0]        r0_op,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic              r1_cin,
  input  logic [1:0]        r1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_f,
  output logic              rsp_dz,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_last_grant;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_f;
  logic              r_rsp_dz;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic              w_grant_vld;
  logic              w_grant_id;
  logic              w_slot_free;
  logic              w_accept;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_cin;
  op_e               w_op;
  logic [DATA_W-1:0] w_f;
  logic              w_dz;

  // Round-robin: under contention the requester that did not win last time goes.
  always_comb begin
    w_grant_vld = r0_valid || r1_valid;
    w_grant_id  = 1'b0;
    if (r0_valid && r1_valid) w_grant_id = ~r_last_grant;
    else if (r1_valid)        w_grant_id = 1'b1;
  end

  assign w_slot_free = (r_state == ST_EMPTY) || rsp_ready;
  assign w_accept    = w_grant_vld && w_slot_free;
  assign r0_ready    = w_grant_vld && !w_grant_id && w_slot_free;
  assign r1_ready    = w_grant_vld &&  w_grant_id && w_slot_free;

  assign w_a   = w_grant_id ? r1_a   : r0_a;
  assign w_b   = w_grant_id ? r1_b   : r0_b;
  assign w_cin = w_grant_id ? r1_cin : r0_cin;
  assign w_op  = op_e'(w_grant_id ? r1_op : r0_op);

  alu_core32 u_core (
    .a   (w_a),
    .b   (w_b),
    .cin (w_cin),
    .op  (w_op),
    .f   (w_f),
    .dz  (w_dz)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
      r_rsp_f      <= '0;
      r_rsp_dz     <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant_id;
      r_rsp_id     <= w_grant_id;
      r_rsp_f      <= w_f;
      r_rsp_dz     <= w_dz;
      if (!w_grant_id && r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + CNT_ONE;
      if ( w_grant_id && r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + CNT_ONE;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_id    = r_rsp_id;
  assign rsp_f     = r_rsp_f;
  assign rsp_dz    = r_rsp_dz;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit add/sub/mul/div datapath between two requesters (req0, req1) using valid/ready handshakes.
- Arbitration is round-robin. The registered result returns on a single response channel, tagged with the requester id.
- Sits between two issue agents (e.g. address-gen and accumulator sequencers) and the arithmetic core.
- Adds divide-by-zero detection and saturating per-requester op counters.

Parameters:
- CNT_W, 16, width of per-requester accepted-op counters (saturating).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 operation valid
- r0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- r0_a  in  32  requester 0 operand A
- r0_b  in  32  requester 0 operand B
- r0_cin  in  1  requester 0 carry-in (OP=00 only)
- r0_op  in  2  requester 0 opcode: 00 add, 01 sub, 10 mul, 11 div
- r1_valid, r1_ready, r1_a, r1_b, r1_cin, r1_op  same as r0_*, for requester 1
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_f  out  32  result
- rsp_dz  out  1  divide-by-zero flag
- cnt0  out  CNT_W  ops accepted from requester 0
- cnt1  out  CNT_W  ops accepted from requester 1

Behaviour:
- Reset values (async on rst_n low):
  - rsp_valid=0, rsp_id=0, rsp_f=0, rsp_dz=0, cnt0=0, cnt1=0.
  - last_grant=1, so req0 wins the first contention.
  - An in-flight held result is discarded; no response is produced for it after reset release.
- State machine:
  - EMPTY: output register free (rsp_valid=0).
  - FULL: result held (rsp_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready with accept (back-to-back).
  - FULL stays FULL while rsp_ready=0.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant, combinational from current valids and last_grant:
  - Only one valid: that requester.
  - Both valid: the requester != last_grant.
  - None valid: no grant.
- Ready: rX_ready = grant==X && slot_free. At most one ready is high per cycle. Ready does not depend on rX_op or operands.
- Accept: rX_valid && rX_ready.
  - On accept: last_grant <= X; the result is computed from the accepted operands and registered.
  - rsp_valid=1 the next cycle (latency 1). rsp_id=X.
- Throughput: 1 op/cycle while rsp_ready=1.
- Backpressure: with rsp_ready=0, rsp_* are held stable and both readies are low.
- Requesters must hold valid and operands until accepted. The arbiter does not drop a pending request; it is re-arbitrated each cycle.
- Arithmetic: unsigned, all results truncated to 32 bits (mod 2^32).
  - add: A+B+cin; cin is ignored for other ops.
  - sub: A-B, wraps (0-1 = 0xFFFF_FFFF).
  - mul: low 32 bits of the product.
  - div: floor(A/B).
  - div with B=0: rsp_f=0xFFFF_FFFF, rsp_dz=1. rsp_dz=0 for all other cases.
- Counters: cntX increments on each accept from X and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous events: rsp_ready and a new accept in the same cycle -> the old result is consumed and the new result is loaded; rsp_valid stays 1.
- Starvation bound: under continuous contention, grants alternate strictly 0,1,0,1...

Decomposition:
- Package alu_share_pkg holds:
  - op enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - DZ_RESULT=32'hFFFF_FFFF.
  - Data width constant = 32.
- Sub-module alu_core32: purely combinational (a, b, cin, op) -> (f, dz). It is instantiated once and fed by the grant-selected operand mux. The arbiter owns all state.

Test Plan:
- Reset then single op: r0 add A=5,B=7,cin=1 accepted at cycle N -> rsp_valid at N+1, rsp_f=13, rsp_id=0, rsp_dz=0, cnt0=1.
- Contention:
  - r0 and r1 both valid, rsp_ready=1, held 4 cycles -> grants 0,1,0,1.
  - r1 div 100/7 -> rsp_f=14 with rsp_id=1.
- Backpressure: rsp_ready=0 for 3 cycles after a result -> rsp_f/rsp_id stable, r0_ready=r1_ready=0. Releasing rsp_ready allows a same-cycle accept; rsp_valid stays 1.
- Boundaries:
  - sub 0-1 -> 0xFFFF_FFFF.
  - add 0xFFFF_FFFF+0+cin=1 -> 0.
  - mul 0x10000*0x10000 -> 0.
  - div 9/0 -> 0xFFFF_FFFF, rsp_dz=1.
- Reset mid-operation: assert rst_n=0 asynchronously while FULL -> rsp_valid=0 immediately, counters 0. First contention after release grants r0.
- Counter saturation with CNT_W=2: 5 accepts from r0 -> cnt0 ends at 3.
